// File: rtl/dp_ram_be_clr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dp_ram_be_clr
// Brief    : Simple dual-port RAM with byte-lane writes, 1/2-cycle reads,
//            selectable read-during-write and a sequential clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module dp_ram_be_clr #(
    parameter int DEPTH      = 16,
    parameter int DWIDTH     = 8,
    parameter int BWIDTH     = 8,
    parameter int AWIDTH     = $clog2(DEPTH),
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = 0,
    parameter int INIT_CLEAR = 1,
    localparam int NLANE     = DWIDTH / BWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_enbl,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [NLANE-1:0]  wr_be,
    input  logic              rd_enbl,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_oor,
    input  logic              clr_req,
    output logic              init_busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AWIDTH:0]   DEPTH_EXT = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST_PTR  = AWIDTH'(DEPTH - 1);

    if (DWIDTH % BWIDTH != 0) begin : g_bad_bwidth
        $fatal(1, "dp_ram_be_clr: DWIDTH must be a multiple of BWIDTH");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $fatal(1, "dp_ram_be_clr: RD_LAT must be 1 or 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "dp_ram_be_clr: DEPTH must be at least 2");
    end

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic                init_busy_q, init_busy_d;
    logic [DWIDTH-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_oor_q, rd_oor_d;

    logic [DWIDTH-1:0]   mem_q [DEPTH];

    logic [DWIDTH-1:0]   wr_mask;
    logic                wr_in_range, rd_in_range;
    logic                wr_acc, rd_acc, collide;
    logic                mem_we;
    logic [AWIDTH-1:0]   mem_waddr;
    logic [DWIDTH-1:0]   mem_wdata, mem_wmask;
    logic [DWIDTH-1:0]   rd_old, rd_word;
    logic                stage_valid, stage_oor;
    logic [DWIDTH-1:0]   stage_data;

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        assign wr_mask[i*BWIDTH +: BWIDTH] = {BWIDTH{wr_be[i]}};
    end

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    assign wr_acc      = (state_q == ST_IDLE) && wr_enbl && wr_in_range;
    assign rd_acc      = (state_q == ST_IDLE) && rd_enbl;
    assign collide     = (RDW_MODE != 0) && wr_acc && rd_in_range && (wr_addr == rd_addr);
    assign rd_old      = rd_in_range ? mem_q[rd_addr] : '0;
    // New-data mode forwards the merged word the write is about to commit.
    assign rd_word     = collide ? ((wr_data & wr_mask) | (rd_old & ~wr_mask)) : rd_old;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wmask = wr_mask;
        case (state_q)
            ST_IDLE: begin
                mem_we = wr_acc;
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                mem_wmask = '1;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        init_busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= (mem_wdata & mem_wmask) | (mem_q[mem_waddr] & ~mem_wmask);
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DWIDTH-1:0] s1_data_q, s1_data_d;
        logic              s1_valid_q, s1_oor_q;

        assign s1_data_d = rd_acc ? rd_word : s1_data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_data_q  <= '0;
                s1_valid_q <= 1'b0;
                s1_oor_q   <= 1'b0;
            end else begin
                s1_data_q  <= s1_data_d;
                s1_valid_q <= rd_acc;
                s1_oor_q   <= rd_acc && !rd_in_range;
            end
        end

        assign stage_valid = s1_valid_q;
        assign stage_oor   = s1_oor_q;
        assign stage_data  = s1_data_q;
    end else begin : g_lat1
        assign stage_valid = rd_acc;
        assign stage_oor   = rd_acc && !rd_in_range;
        assign stage_data  = rd_word;
    end

    always_comb begin
        rd_valid_d = stage_valid;
        rd_oor_d   = stage_oor;
        rd_data_d  = stage_valid ? stage_data : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
            clr_ptr_q   <= '0;
            init_busy_q <= (INIT_CLEAR != 0);
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_oor_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            init_busy_q <= init_busy_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_oor_q    <= rd_oor_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_oor    = rd_oor_q;
    assign init_busy = init_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_be_clr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dp_ram_be_clr
// Brief    : Drives two dp_ram_be_clr configurations with shared directed
//            stimulus and checks both against a behavioural RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_ram_be_clr;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_enbl, rd_enbl, clr_req;
    logic [3:0]  wr_addr, rd_addr, wr_be;
    logic [31:0] wr_data;

    logic [1:0][31:0] rd_data_w;
    logic [1:0]       rd_valid_w, rd_oor_w, busy_w;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;

    // Instance 0: DEPTH 16, latency 1, old-data; instance 1: DEPTH 12, latency 2, new-data.
    int p_depth [2] = '{16, 12};
    int p_lat   [2] = '{1, 2};
    int p_mode  [2] = '{0, 1};

    always #5 clk = ~clk;

    dp_ram_be_clr #(.DEPTH(16), .DWIDTH(32), .BWIDTH(8), .RD_LAT(1), .RDW_MODE(0), .INIT_CLEAR(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .wr_enbl(wr_enbl), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_enbl(rd_enbl), .rd_addr(rd_addr),
        .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]), .rd_oor(rd_oor_w[0]),
        .clr_req(clr_req), .init_busy(busy_w[0])
    );

    dp_ram_be_clr #(.DEPTH(12), .DWIDTH(32), .BWIDTH(8), .RD_LAT(2), .RDW_MODE(1), .INIT_CLEAR(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .wr_enbl(wr_enbl), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_enbl(rd_enbl), .rd_addr(rd_addr),
        .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]), .rd_oor(rd_oor_w[1]),
        .clr_req(clr_req), .init_busy(busy_w[1])
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem  [2][16];
    bit          m_busy [2];
    int          m_rem  [2];
    logic [31:0] m_last [2];
    bit          s_v    [2][4];
    logic [31:0] s_d    [2][4];
    bit          s_o    [2][4];
    bit          e_v [2], e_o [2], e_b [2];
    logic [31:0] e_d [2];

    typedef struct packed {
        logic [1:0]  k;
        logic [31:0] ed;
        logic [31:0] d;
        logic        o;
    } cap_t;
    cap_t caps[$];

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
    end

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++)
            if (be[l]) r[l*8 +: 8] = nw[l*8 +: 8];
        return r;
    endfunction

    task automatic model_step(input int k);
        int          d, slot, due;
        logic [31:0] val;
        bit          o;
        d    = p_depth[k];
        slot = edge_n % 4;
        if (rst) begin
            m_busy[k] = 1'b1;
            m_rem[k]  = d;
            m_last[k] = '0;
            for (int i = 0; i < 4; i++) s_v[k][i] = 1'b0;
            e_v[k] = 1'b0; e_o[k] = 1'b0; e_d[k] = '0; e_b[k] = 1'b1;
            return;
        end
        if (!m_busy[k] && rd_enbl) begin
            if (int'(rd_addr) >= d) begin
                val = '0; o = 1'b1;
            end else begin
                o   = 1'b0;
                val = m_mem[k][rd_addr];
                if (p_mode[k] == 1 && wr_enbl && wr_addr == rd_addr)
                    val = merge(val, wr_data, wr_be);
            end
            due = (edge_n + p_lat[k] - 1) % 4;
            s_v[k][due] = 1'b1; s_d[k][due] = val; s_o[k][due] = o;
        end
        if (!m_busy[k] && wr_enbl && int'(wr_addr) < d)
            m_mem[k][wr_addr] = merge(m_mem[k][wr_addr], wr_data, wr_be);
        if (m_busy[k]) begin
            m_mem[k][d - m_rem[k]] = '0;
            m_rem[k]--;
            if (m_rem[k] == 0) m_busy[k] = 1'b0;
        end else if (clr_req) begin
            m_busy[k] = 1'b1;
            m_rem[k]  = d;
        end
        if (s_v[k][slot]) begin
            e_v[k] = 1'b1; e_d[k] = s_d[k][slot]; e_o[k] = s_o[k][slot];
            m_last[k] = s_d[k][slot];
        end else begin
            e_v[k] = 1'b0; e_d[k] = m_last[k]; e_o[k] = 1'b0;
        end
        s_v[k][slot] = 1'b0;
        e_b[k] = m_busy[k];
    endtask

    always @(posedge clk) begin
        edge_n++;
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (rd_valid_w[k] !== e_v[k] || rd_oor_w[k] !== e_o[k] ||
                rd_data_w[k] !== e_d[k] || busy_w[k] !== e_b[k]) begin
                miscompares++;
                $display("FAIL cycle dut%0d edge %0d: got v=%b o=%b d=%h busy=%b, want v=%b o=%b d=%h busy=%b",
                         k, edge_n, rd_valid_w[k], rd_oor_w[k], rd_data_w[k], busy_w[k],
                         e_v[k], e_o[k], e_d[k], e_b[k]);
            end
            if (rd_valid_w[k] === 1'b1)
                caps.push_back('{k: 2'(k), ed: 32'(edge_n), d: rd_data_w[k], o: rd_oor_w[k]});
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic expect_read(input string name, input int k, input logic [31:0] d,
                               input bit o, input int edge_want);
        cap_t c;
        bit   ok;
        ok = 1'b0;
        c  = '0;
        for (int i = 0; i < caps.size(); i++) begin
            if (int'(caps[i].k) == k) begin
                c = caps[i]; caps.delete(i); ok = 1'b1; break;
            end
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL %s dut%0d: got no rd_valid, want data %h", name, k, d);
        end else begin
            chk({name, " data"}, c.d, d);
            chk({name, " oor"}, 32'(c.o), 32'(o));
            if (edge_want >= 0) chk({name, " edge"}, c.ed, 32'(edge_want));
        end
    endtask

    task automatic step(input bit we, input int wa, input logic [31:0] wd, input logic [3:0] be,
                        input bit re, input int ra, input bit clr);
        wr_enbl = we; wr_addr = 4'(wa); wr_data = wd; wr_be = be;
        rd_enbl = re; rd_addr = 4'(ra); clr_req = clr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, '0, '0, 0, 0, 0);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && busy_w != 2'b00; i++) idle(1);
        if (busy_w != 2'b00) begin
            vectors++; miscompares++;
            $display("FAIL %s timeout: got init_busy=%b, want 00", name, busy_w);
        end
    endtask

    task automatic read_all();
        caps.delete();
        for (int a = 0; a < 16; a++) step(0, 0, '0, '0, 1, a, 0);
        idle(3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int cnt0, cnt1, e0;
        rst = 1'b1;
        wr_enbl = 0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_enbl = 0; rd_addr = '0; clr_req = 0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy_w), 32'h3);
        chk("reset rd_valid", 32'(rd_valid_w), 32'h0);
        rst = 1'b0;

        // Power-up clear length.
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 40 && busy_w != 2'b00; i++) begin
            cnt0 += int'(busy_w[0]);
            cnt1 += int'(busy_w[1]);
            idle(1);
        end
        chk("init busy cycles dut0", 32'(cnt0), 32'd16);
        chk("init busy cycles dut1", 32'(cnt1), 32'd12);
        wait_idle("init clear");

        // Cleared array reads back zero; dut1 addresses 12..15 are out of range.
        read_all();
        for (int a = 0; a < 16; a++) begin
            expect_read($sformatf("clear rd%0d", a), 0, 32'h0, 1'b0, -1);
            expect_read($sformatf("clear rd%0d", a), 1, 32'h0, a >= 12, -1);
        end

        // Byte-lane merge.
        caps.delete();
        step(1, 3, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        step(1, 3, 32'h11223344, 4'b0101, 0, 0, 0);
        step(0, 0, '0, '0, 1, 3, 0);
        idle(3);
        expect_read("be merge", 0, 32'hAA22CC44, 1'b0, -1);
        expect_read("be merge", 1, 32'hAA22CC44, 1'b0, -1);

        // Same-edge read/write collision, then the following read.
        caps.delete();
        step(1, 7, 32'h0000005A, 4'hF, 1, 7, 0);
        step(0, 0, '0, '0, 1, 7, 0);
        idle(3);
        expect_read("rdw old", 0, 32'h00000000, 1'b0, -1);
        expect_read("rdw next", 0, 32'h0000005A, 1'b0, -1);
        expect_read("rdw new", 1, 32'h0000005A, 1'b0, -1);
        expect_read("rdw next", 1, 32'h0000005A, 1'b0, -1);

        // Back-to-back reads and latency.
        for (int a = 0; a < 3; a++) step(1, a, 32'h100 + a, 4'hF, 0, 0, 0);
        caps.delete();
        e0 = edge_n + 1;
        for (int a = 0; a < 3; a++) step(0, 0, '0, '0, 1, a, 0);
        idle(3);
        for (int a = 0; a < 3; a++) begin
            expect_read($sformatf("b2b rd%0d", a), 0, 32'h100 + a, 1'b0, e0 + a);
            expect_read($sformatf("b2b rd%0d", a), 1, 32'h100 + a, 1'b0, e0 + 1 + a);
        end

        // Out-of-range read and write.
        caps.delete();
        step(0, 0, '0, '0, 1, 13, 0);
        idle(3);
        expect_read("oor rd13", 0, 32'h0, 1'b0, -1);
        expect_read("oor rd13", 1, 32'h0, 1'b1, -1);
        step(1, 14, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        read_all();
        expect_read("after oor wr rd0", 1, 32'h100, 1'b0, -1);

        // Independent simultaneous write/read at different addresses with assorted lanes.
        for (int i = 0; i < 8; i++)
            step(1, (i * 3) % 16, 32'h01020304 * (i + 1), 4'(i * 7 + 1), 1, (i * 5 + 1) % 16, 0);
        read_all();

        // Clear request interrupted by reset, writes during busy are lost.
        for (int a = 0; a < 16; a++) step(1, a, 32'hC0DE0000 | a, 4'hF, 0, 0, 0);
        step(0, 0, '0, '0, 0, 0, 1);
        idle(5);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(1, i, 32'hDEAD0000 | i, 4'hF, 1, i, 0);
        wait_idle("restarted clear");
        read_all();
        for (int a = 0; a < 16; a++) begin
            expect_read($sformatf("reclear rd%0d", a), 0, 32'h0, 1'b0, -1);
            expect_read($sformatf("reclear rd%0d", a), 1, 32'h0, a >= 12, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dp_ram_be_clr.md
Name: dp_ram_be_clr

Overview:
Parametrised successor to the simple dual-port RAM. It has one synchronous write port with per-lane byte enables and one synchronous read port. Read latency is selectable, with a rd_valid strobe. Read-during-write collision behaviour is selectable. A sequential clear engine zeroes the whole array after reset or on request. The block is the DUT behind the next-generation RAM layered testbench and replaces the plain enable/addr/data RAM.

Parameters:
DEPTH, 16, number of words; any value >= 2 (not necessarily a power of two)
DWIDTH, 8, word width in bits
BWIDTH, 8, byte-lane width; DWIDTH % BWIDTH must be 0, otherwise $fatal at elaboration
AWIDTH, $clog2(DEPTH), address width
NLANE, DWIDTH/BWIDTH, number of byte-enable bits (derived; not overridable)
RD_LAT, 1, read latency in clock edges; legal values 1 or 2, otherwise $fatal
RDW_MODE, 0, same-address read during write: 0 returns old data, 1 returns new (merged) data
INIT_CLEAR, 1, 1 means the clear engine runs automatically after reset deassertion

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
wr_enbl  input  1  write request
wr_addr  input  AWIDTH  write address
wr_data  input  DWIDTH  write data
wr_be  input  NLANE  byte-lane write enables; lane i covers bits [i*BWIDTH +: BWIDTH]
rd_enbl  input  1  read request
rd_addr  input  AWIDTH  read address
rd_data  output  DWIDTH  read data
rd_valid  output  1  one-cycle strobe marking rd_data as the result of a read
rd_oor  output  1  pulses alongside rd_valid when the read address was >= DEPTH
clr_req  input  1  request a full-array clear
init_busy  output  1  high while the clear engine is running

Behaviour:
- Reset (async assert) drives: rd_data=0, rd_valid=0, rd_oor=0, pipeline registers=0, FSM=CLEAR if INIT_CLEAR=1 else IDLE, init_busy=INIT_CLEAR, clear counter=0. Array contents are not reset directly.
- FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR on clr_req=1.
  - In CLEAR, one word is zeroed per cycle at clear_ptr, which runs 0..DEPTH-1.
  - After the DEPTH-1 write: CLEAR -> IDLE and init_busy falls on that same edge.
  - A full clear takes exactly DEPTH cycles.
  - clr_req is ignored while in CLEAR.
  - Reset asserted mid-clear restarts the clear from address 0.
- init_busy is registered and equals (state==CLEAR).
- While init_busy=1:
  - wr_enbl, rd_enbl and wr_be are ignored.
  - No rd_valid is issued.
  - Reads already in the pipeline still complete.
- Write, in IDLE with wr_enbl=1 and wr_addr<DEPTH: at the posedge, lane i is updated iff wr_be[i]=1; other lanes keep old contents.
  - wr_be=0 is a legal no-op.
  - wr_addr>=DEPTH is silently dropped.
- Read, in IDLE with rd_enbl=1, sampled at edge N:
  - RD_LAT=1: rd_data and rd_valid update at edge N (visible after N).
  - RD_LAT=2: one extra register stage; result appears at edge N+1.
  - Back-to-back reads give one result per cycle with no bubbles.
- Out-of-range read (rd_addr>=DEPTH): rd_data=0, rd_valid=1, rd_oor=1, with the same latency as a normal read.
- rd_valid and rd_oor are single-cycle strobes. rd_data holds its last value when rd_valid=0.
- Collision (wr_enbl & rd_enbl, same in-range address, same edge):
  - RDW_MODE=0: read returns the pre-write word.
  - RDW_MODE=1: read returns (wr_data & mask) | (old & ~mask), where mask is expanded from wr_be.
  - The write always commits.
- A read issued one edge after a write to the same address always sees the new data, in both modes.
- Different-address simultaneous read and write are independent.

Test Plan:
1. Reset, INIT_CLEAR=1, DEPTH=16 -> init_busy high for exactly 16 cycles after rst falls; then reading addresses 0..15 all return 0, each with rd_valid after RD_LAT.
2. DWIDTH=32, BWIDTH=8: write 0xAABBCCDD with be=4'hF to addr 3, then 0x11223344 with be=4'b0101 -> reading addr 3 returns 0xAA22CC44.
3. Same-edge write 0x5A / read at addr 7 (old=0x00) -> RDW_MODE=0 returns 0x00; RDW_MODE=1 returns 0x5A; a read on the next cycle returns 0x5A in both modes.
4. RD_LAT=2: reads of addr 0,1,2 on consecutive edges -> three consecutive rd_valid pulses starting 2 edges after the first request, with data in request order.
5. DEPTH=12: read addr 13 -> rd_data=0, rd_valid=1, rd_oor=1; write addr 14 -> no array word changes.
6. clr_req issued, then rst pulsed at clear_ptr=5 -> clear restarts from 0; writes issued during init_busy are lost; after completion the whole array reads 0.
